// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS datapath blocks.
package mips_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 64;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // True when a word index falls inside an array of 'depth' words.
    function automatic logic idx_in_range(input logic [ADDR_W-1:0] idx,
                                          input int unsigned depth);
        return 32'(idx) < depth;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational read, synchronous load port,
// asynchronous active-low reset that clears every word to NOP.
module instruction_memory
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A,
    output logic [WIDTH-1:0]  RD,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= WIDTH'(NOP);
            end
        end else if (WE && idx_in_range(WA, DEPTH)) begin
            mem[WA[IDX_W-1:0]] <= WD;
        end
    end

    // Out-of-range fetches decode as NOP; no bypass from the load port.
    assign RD = idx_in_range(A, DEPTH) ? mem[A[IDX_W-1:0]] : WIDTH'(NOP);

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory at DEPTH=64 and DEPTH=256 side by side.
module tb_instruction_memory;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b1;
    logic        WE = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  WA = '0;
    logic [31:0] WD = '0;
    logic [31:0] rd64;
    logic [31:0] rd256;

    int checks = 0;
    int failures = 0;

    // Reference contents: one word per index, each array knows its own depth.
    logic [31:0] ref64 [256];
    logic [31:0] ref256 [256];

    instruction_memory #(.WIDTH(32), .DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .RD    (rd64),
        .WE    (WE),
        .WA    (WA),
        .WD    (WD)
    );

    instruction_memory #(.WIDTH(32), .DEPTH(256)) dut256 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .RD    (rd256),
        .WE    (WE),
        .WA    (WA),
        .WD    (WD)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [31:0] exp64(input int a);
        return (a < 64) ? ref64[a] : 32'h0;
    endfunction

    function automatic logic [31:0] exp256(input int a);
        return ref256[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            ref64[i]  = 32'h0;
            ref256[i] = 32'h0;
        end
    endtask

    task automatic model_write(input int wa, input logic [31:0] wd);
        if (wa < 64) ref64[wa] = wd;
        ref256[wa] = wd;
    endtask

    task automatic write_word(input int wa, input logic [31:0] wd);
        @(negedge clk);
        WE = 1'b1;
        WA = 8'(wa);
        WD = wd;
        @(posedge clk);
        #1;
        WE = 1'b0;
        if (rst_n) model_write(wa, wd);
    endtask

    task automatic test_reset();
        int pts [5] = '{0, 5, 15, 19, 63};
        #1;
        rst_n = 1'b0;
        model_clear();
        foreach (pts[k]) begin
            A = 8'(pts[k]);
            #1;
            checks++;
            if (rd64 !== 32'h0) begin
                $display("FAIL reset_rd64 A=%0d got=%h exp=%h", pts[k], rd64, 32'h0);
                failures++;
            end
            checks++;
            if (rd256 !== 32'h0) begin
                $display("FAIL reset_rd256 A=%0d got=%h exp=%h", pts[k], rd256, 32'h0);
                failures++;
            end
        end
        #3;
        rst_n = 1'b1;
        clk_run = 1'b1;
    endtask

    task automatic test_load_read();
        int pts [17] = '{5, 15, 19, 6, 0, 2, 4, 7, 11, 33, 34, 9, 1, 17, 12, 20, 40};
        for (int i = 0; i < 64; i++) write_word(i, 32'hA000_0000 + 32'(i));
        foreach (pts[k]) begin
            A = 8'(pts[k]);
            #1;
            checks++;
            if (rd64 !== 32'hA000_0000 + 32'(pts[k])) begin
                $display("FAIL load_read A=%0d got=%h exp=%h", pts[k], rd64,
                         32'hA000_0000 + 32'(pts[k]));
                failures++;
            end
            checks++;
            if (rd256 !== exp256(pts[k])) begin
                $display("FAIL load_read256 A=%0d got=%h exp=%h", pts[k], rd256,
                         exp256(pts[k]));
                failures++;
            end
            #4;
        end
    endtask

    task automatic test_out_of_range();
        int pts [5] = '{64, 77, 111, 122, 255};
        foreach (pts[k]) begin
            A = 8'(pts[k]);
            #1;
            checks++;
            if (rd64 !== 32'h0) begin
                $display("FAIL oor_read A=%0d got=%h exp=%h", pts[k], rd64, 32'h0);
                failures++;
            end
        end
        write_word(100, 32'hDEAD_BEEF);
        for (int i = 0; i < 64; i++) begin
            A = 8'(i);
            #1;
            checks++;
            if (rd64 !== exp64(i)) begin
                $display("FAIL oor_write_disturb A=%0d got=%h exp=%h", i, rd64, exp64(i));
                failures++;
            end
        end
        A = 8'd100;
        #1;
        checks++;
        if (rd64 !== 32'h0) begin
            $display("FAIL oor_read100 got=%h exp=%h", rd64, 32'h0);
            failures++;
        end
        checks++;
        if (rd256 !== 32'hDEAD_BEEF) begin
            $display("FAIL wide_write100 got=%h exp=%h", rd256, 32'hDEAD_BEEF);
            failures++;
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        A  = 8'd5;
        WE = 1'b1;
        WA = 8'd5;
        WD = 32'h1234_5678;
        #4;
        checks++;
        if (rd64 !== exp64(5)) begin
            $display("FAIL rdw_before_edge got=%h exp=%h", rd64, exp64(5));
            failures++;
        end
        @(posedge clk);
        #1;
        model_write(5, 32'h1234_5678);
        WE = 1'b0;
        checks++;
        if (rd64 !== exp64(5)) begin
            $display("FAIL rdw_after_edge got=%h exp=%h", rd64, exp64(5));
            failures++;
        end
        @(negedge clk);
        WA = 8'd5;
        WD = 32'h8765_4321;
        @(posedge clk);
        #1;
        checks++;
        if (rd64 !== exp64(5)) begin
            $display("FAIL we_low_no_write got=%h exp=%h", rd64, exp64(5));
            failures++;
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        #1;
        A  = 8'd5;
        WE = 1'b1;
        WA = 8'd7;
        WD = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (rd64 !== exp64(5)) begin
            $display("FAIL pre_reset_A5 got=%h exp=%h", rd64, exp64(5));
            failures++;
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rd64 !== 32'h0) begin
            $display("FAIL mid_reset_A5 got=%h exp=%h", rd64, 32'h0);
            failures++;
        end
        A = 8'd15;
        #1;
        checks++;
        if (rd64 !== 32'h0) begin
            $display("FAIL mid_reset_A15 got=%h exp=%h", rd64, 32'h0);
            failures++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            A = 8'(i);
            #1;
            checks++;
            if (rd64 !== 32'h0 || rd256 !== 32'h0) begin
                $display("FAIL reset_we_ignored A=%0d got=%h/%h exp=%h", i, rd64, rd256,
                         32'h0);
                failures++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        A  = 8'd7;
        WE = 1'b1;
        WA = 8'd7;
        WD = 32'h7777_0007;
        @(posedge clk);
        #1;
        WE = 1'b0;
        model_write(7, 32'h7777_0007);
        checks++;
        if (rd64 !== exp64(7)) begin
            $display("FAIL first_write_after_reset got=%h exp=%h", rd64, exp64(7));
            failures++;
        end
    endtask

    task automatic test_depth256();
        int pts [4] = '{122, 255, 64, 200};
        for (int i = 0; i < 256; i++) write_word(i, 32'hA000_0000 + 32'(i));
        foreach (pts[k]) begin
            A = 8'(pts[k]);
            #1;
            checks++;
            if (rd256 !== 32'hA000_0000 + 32'(pts[k])) begin
                $display("FAIL depth256_read A=%0d got=%h exp=%h", pts[k], rd256,
                         32'hA000_0000 + 32'(pts[k]));
                failures++;
            end
            checks++;
            if (rd64 !== 32'h0) begin
                $display("FAIL depth64_oor A=%0d got=%h exp=%h", pts[k], rd64, 32'h0);
                failures++;
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            WE = 1'($urandom_range(0, 1));
            WA = 8'($urandom);
            WD = $urandom;
            A  = (n % 3 == 0) ? WA : 8'($urandom);
            #1;
            checks++;
            if (rd64 !== exp64(int'(A)) || rd256 !== exp256(int'(A))) begin
                $display("FAIL random_pre n=%0d A=%0d got=%h/%h exp=%h/%h", n, A, rd64, rd256,
                         exp64(int'(A)), exp256(int'(A)));
                failures++;
            end
            @(posedge clk);
            #1;
            if (WE) model_write(int'(WA), WD);
            checks++;
            if (rd64 !== exp64(int'(A)) || rd256 !== exp256(int'(A))) begin
                $display("FAIL random_post n=%0d A=%0d got=%h/%h exp=%h/%h", n, A, rd64, rd256,
                         exp64(int'(A)), exp256(int'(A)));
                failures++;
            end
            WE = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_out_of_range();
        test_read_during_write();
        test_mid_reset();
        test_depth256();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
